// File: rtl/stack_pkg.sv
// Shared constants and the per-cycle operation encoding for the LIFO stack unit.
package stack_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 1024;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_ERR
  } op_e;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port and two asynchronous read ports.
module stack_ram
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     top_addr,
  output logic [DATA_W-1:0] top_data,
  input  logic [AW-1:0]     pop_addr,
  output logic [DATA_W-1:0] pop_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; entries are only ever read after being written,
  // and a resettable array would prevent mapping onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign top_data = mem[top_addr];
  assign pop_data = mem[pop_addr];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack: pointer, sticky error flags, per-cycle op decode and registered pop output.
module stack_unit
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              pop_valid,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0]  sp_q, sp_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              pop_valid_q, pop_valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              armed_q, armed_d;

  op_e               op;
  logic              ovf_evt, udf_evt;
  logic              empty_w, full_w;
  logic              we;
  logic [AW-1:0]     waddr, top_addr;
  logic [DATA_W-1:0] rd_top, rd_pop;

  assign empty_w  = (sp_q == '0);
  assign full_w   = (sp_q == CNT_W'(DEPTH));
  // At sp == DEPTH the low bits are zero, so the modular decrement still lands on DEPTH-1.
  assign top_addr = sp_q[AW-1:0] - AW'(1);

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    op      = OP_NONE;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    // armed_q is low on the edge coincident with reset release, so nothing is accepted there.
    if (armed_q) begin
      case ({push, pop})
        2'b10: begin
          if (full_w) begin
            op      = OP_ERR;
            ovf_evt = 1'b1;
          end else begin
            op = OP_PUSH;
          end
        end
        2'b01: begin
          if (empty_w) begin
            op      = OP_ERR;
            udf_evt = 1'b1;
          end else begin
            op = OP_POP;
          end
        end
        2'b11: begin
          // Replace needs a top entry; on an empty stack it degrades to a plain push.
          if (empty_w) begin
            op      = OP_PUSH;
            udf_evt = 1'b1;
          end else begin
            op = OP_REPLACE;
          end
        end
        default: op = OP_NONE;
      endcase
    end
  end

  always_comb begin
    sp_d        = sp_q;
    data_out_d  = data_out_q;
    pop_valid_d = 1'b0;
    we          = 1'b0;
    waddr       = sp_q[AW-1:0];
    case (op)
      OP_PUSH: begin
        we   = 1'b1;
        sp_d = sp_q + CNT_W'(1);
      end
      OP_POP: begin
        data_out_d  = rd_pop;
        pop_valid_d = 1'b1;
        sp_d        = sp_q - CNT_W'(1);
      end
      OP_REPLACE: begin
        we          = 1'b1;
        waddr       = top_addr;
        data_out_d  = rd_pop;
        pop_valid_d = 1'b1;
      end
      default: ;
    endcase
    ovf_d   = (ovf_q & ~clr_err) | ovf_evt;
    udf_d   = (udf_q & ~clr_err) | udf_evt;
    armed_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q        <= '0;
      data_out_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      data_out_q  <= data_out_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      armed_q     <= armed_d;
    end
  end

  stack_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (data_in),
    .top_addr(top_addr),
    .top_data(rd_top),
    .pop_addr(top_addr),
    .pop_data(rd_pop)
  );

  assign data_out  = data_out_q;
  assign pop_valid = pop_valid_q;
  assign top       = rd_top;
  assign count     = sp_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed and model-checked random stimulus for stack_unit at DATA_W=32, DEPTH=4.
module tb_stack_unit;

  logic        clk;
  logic        reset_n;
  logic        push;
  logic        pop;
  logic [31:0] data_in;
  logic        clr_err;
  logic [31:0] data_out;
  logic        pop_valid;
  logic [31:0] top;
  logic [2:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  int n_checks;
  int n_errors;

  stack_unit #(
    .DATA_W(32),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .clr_err  (clr_err),
    .data_out (data_out),
    .pop_valid(pop_valid),
    .top      (top),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // One clock: inputs applied now, outputs sampled 1 time unit after the edge.
  task automatic step(input logic p, input logic o, input logic [31:0] d, input logic c);
    push    = p;
    pop     = o;
    data_in = d;
    clr_err = c;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
  endtask

  // Release reset exactly on a clock edge while a push is requested; that edge must not act.
  task automatic release_reset();
    push    = 1'b1;
    data_in = 32'hDEAD;
    @(posedge clk);
    reset_n = 1'b1;
    #1;
    push = 1'b0;
    n_checks++;
    if (count !== 3'd0 || empty !== 1'b1)
      begin n_errors++; $display("FAIL release_edge: count=%0d empty=%b, expected count=0 empty=1", count, empty); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({count, empty, full, data_out, pop_valid, overflow, underflow} !== {3'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0})
      begin n_errors++; $display("FAIL reset_values: count=%0d empty=%b full=%b data_out=%h pv=%b ovf=%b udf=%b, expected 0 1 0 0 0 0 0",
                                 count, empty, full, data_out, pop_valid, overflow, underflow); end
    release_reset();
  endtask

  task automatic test_lifo();
    step(1, 0, 32'hA, 0);
    step(1, 0, 32'hB, 0);
    step(1, 0, 32'hC, 0);
    n_checks++;
    if (count !== 3'd3 || top !== 32'hC)
      begin n_errors++; $display("FAIL lifo_fill: count=%0d top=%h, expected 3 c", count, top); end
    step(0, 1, 0, 0);
    n_checks++;
    if (data_out !== 32'hC || pop_valid !== 1'b1)
      begin n_errors++; $display("FAIL lifo_pop1: data_out=%h pv=%b, expected c 1", data_out, pop_valid); end
    step(0, 0, 0, 0);
    n_checks++;
    if (data_out !== 32'hC || pop_valid !== 1'b0)
      begin n_errors++; $display("FAIL lifo_idle_hold: data_out=%h pv=%b, expected c 0", data_out, pop_valid); end
    step(0, 1, 0, 0);
    n_checks++;
    if (data_out !== 32'hB || pop_valid !== 1'b1)
      begin n_errors++; $display("FAIL lifo_pop2: data_out=%h pv=%b, expected b 1", data_out, pop_valid); end
    step(0, 1, 0, 0);
    n_checks++;
    if (data_out !== 32'hA || pop_valid !== 1'b1 || empty !== 1'b1 || count !== 3'd0)
      begin n_errors++; $display("FAIL lifo_pop3: data_out=%h pv=%b empty=%b count=%0d, expected a 1 1 0", data_out, pop_valid, empty, count); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 3; i++) step(1, 0, 32'(i), 0);
    n_checks++;
    if (full !== 1'b0 || count !== 3'd3)
      begin n_errors++; $display("FAIL ovf_not_full: full=%b count=%0d, expected 0 3", full, count); end
    step(1, 0, 32'd4, 0);
    n_checks++;
    if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0)
      begin n_errors++; $display("FAIL ovf_full: full=%b count=%0d ovf=%b, expected 1 4 0", full, count, overflow); end
    step(1, 0, 32'd5, 0);
    n_checks++;
    if (overflow !== 1'b1 || count !== 3'd4 || top !== 32'd4)
      begin n_errors++; $display("FAIL ovf_set: ovf=%b count=%0d top=%h, expected 1 4 4", overflow, count, top); end
    step(0, 1, 0, 0);
    n_checks++;
    if (data_out !== 32'd4 || pop_valid !== 1'b1 || overflow !== 1'b1)
      begin n_errors++; $display("FAIL ovf_pop: data_out=%h pv=%b ovf=%b, expected 4 1 1", data_out, pop_valid, overflow); end
    step(0, 0, 0, 1);
    n_checks++;
    if (overflow !== 1'b0)
      begin n_errors++; $display("FAIL ovf_clear: ovf=%b, expected 0", overflow); end
    for (int i = 3; i >= 1; i--) begin
      step(0, 1, 0, 0);
      n_checks++;
      if (data_out !== 32'(i) || pop_valid !== 1'b1)
        begin n_errors++; $display("FAIL ovf_drain: data_out=%h pv=%b, expected %h 1", data_out, pop_valid, i); end
    end
  endtask

  task automatic test_underflow();
    step(0, 1, 0, 0);
    n_checks++;
    if (underflow !== 1'b1 || pop_valid !== 1'b0 || data_out !== 32'd1 || count !== 3'd0)
      begin n_errors++; $display("FAIL udf_pop_empty: udf=%b pv=%b data_out=%h count=%0d, expected 1 0 1 0", underflow, pop_valid, data_out, count); end
    step(1, 1, 32'h7, 0);
    n_checks++;
    if (count !== 3'd1 || top !== 32'h7 || underflow !== 1'b1 || pop_valid !== 1'b0 || data_out !== 32'd1)
      begin n_errors++; $display("FAIL udf_replace_empty: count=%0d top=%h udf=%b pv=%b data_out=%h, expected 1 7 1 0 1",
                                 count, top, underflow, pop_valid, data_out); end
    step(0, 0, 0, 1);
    n_checks++;
    if (underflow !== 1'b0)
      begin n_errors++; $display("FAIL udf_clear: udf=%b, expected 0", underflow); end
    step(0, 1, 0, 0);
    n_checks++;
    if (data_out !== 32'h7 || pop_valid !== 1'b1 || empty !== 1'b1)
      begin n_errors++; $display("FAIL udf_pop_seven: data_out=%h pv=%b empty=%b, expected 7 1 1", data_out, pop_valid, empty); end
    step(0, 1, 0, 1);
    n_checks++;
    if (underflow !== 1'b1)
      begin n_errors++; $display("FAIL udf_set_wins: udf=%b, expected 1", underflow); end
    step(0, 0, 0, 1);
    n_checks++;
    if (underflow !== 1'b0)
      begin n_errors++; $display("FAIL udf_clear2: udf=%b, expected 0", underflow); end
  endtask

  task automatic test_replace_full();
    for (int i = 1; i <= 4; i++) step(1, 0, 32'(i), 0);
    step(1, 1, 32'h9, 0);
    n_checks++;
    if (data_out !== 32'd4 || pop_valid !== 1'b1 || count !== 3'd4 || top !== 32'h9 || overflow !== 1'b0 || full !== 1'b1)
      begin n_errors++; $display("FAIL replace_full: data_out=%h pv=%b count=%0d top=%h ovf=%b full=%b, expected 4 1 4 9 0 1",
                                 data_out, pop_valid, count, top, overflow, full); end
    step(0, 1, 0, 0);
    n_checks++;
    if (data_out !== 32'h9 || count !== 3'd3)
      begin n_errors++; $display("FAIL replace_pop: data_out=%h count=%0d, expected 9 3", data_out, count); end
    for (int i = 3; i >= 1; i--) step(0, 1, 0, 0);
    n_checks++;
    if (data_out !== 32'd1 || empty !== 1'b1)
      begin n_errors++; $display("FAIL replace_drain: data_out=%h empty=%b, expected 1 1", data_out, empty); end
  endtask

  task automatic test_mid_reset();
    step(1, 0, 32'h1, 0);
    step(1, 0, 32'h2, 0);
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if (count !== 3'd0 || empty !== 1'b1 || data_out !== 32'd0 || pop_valid !== 1'b0)
      begin n_errors++; $display("FAIL mid_reset: count=%0d empty=%b data_out=%h pv=%b, expected 0 1 0 0", count, empty, data_out, pop_valid); end
    release_reset();
    step(1, 0, 32'h3, 0);
    step(0, 1, 0, 0);
    n_checks++;
    if (data_out !== 32'h3 || pop_valid !== 1'b1 || empty !== 1'b1)
      begin n_errors++; $display("FAIL mid_reset_after: data_out=%h pv=%b empty=%b, expected 3 1 1", data_out, pop_valid, empty); end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] exp_do;
    logic        exp_pv, m_ovf, m_udf, new_o, new_u;
    logic        p, o, c;
    logic [31:0] d;
    logic [40:0] got_v, exp_v;
    #3 reset_n = 1'b0;
    #1;
    release_reset();
    exp_do = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      p = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 5);
      d = $urandom;
      step(p, o, d, c);
      new_o  = 1'b0;
      new_u  = 1'b0;
      exp_pv = 1'b0;
      if (p && o) begin
        if (q.size() == 0) begin
          q.push_back(d);
          new_u = 1'b1;
        end else begin
          exp_do = q[q.size()-1];
          q[q.size()-1] = d;
          exp_pv = 1'b1;
        end
      end else if (p) begin
        if (q.size() == 4) new_o = 1'b1;
        else q.push_back(d);
      end else if (o) begin
        if (q.size() == 0) new_u = 1'b1;
        else begin
          exp_do = q.pop_back();
          exp_pv = 1'b1;
        end
      end
      m_ovf = (m_ovf && !c) || new_o;
      m_udf = (m_udf && !c) || new_u;
      got_v = {data_out, pop_valid, count, empty, full, overflow, underflow};
      exp_v = {exp_do, exp_pv, 3'(q.size()), q.size() == 0, q.size() == 4, m_ovf, m_udf};
      n_checks++;
      if (got_v !== exp_v)
        begin n_errors++; $display("FAIL random_state cycle %0d: got %h expected %h", cyc, got_v, exp_v); end
      if (q.size() != 0) begin
        n_checks++;
        if (top !== q[q.size()-1])
          begin n_errors++; $display("FAIL random_top cycle %0d: got %h expected %h", cyc, top, q[q.size()-1]); end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b1;
    push     = 1'b0;
    pop      = 1'b0;
    data_in  = '0;
    clr_err  = 1'b0;
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_replace_full();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
